// File: rtl/clkdiv_burst.sv
// rtl/clkdiv_burst.sv - burst sequencer driving an internal clock divider for exactly N sclk pulses
//
// clkdiv: divider producing DIV/2-cycle active pulses separated by DIV-DIV/2 idle cycles.
//   clk_i   system clock
//   rst_i   synchronous active-high reset; only cancels a pending continuation
//   en_i    enable; starts a pulse from idle, or commits the next pulse when seen in the RTI cycle
//   sclk_o  divided clock, idle level IDLE_HIGH
//
// clkdiv_burst: accepts a pulse-count request and sequences the divider enable.
//   clk_i, rst_i                  clock and synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake, req_count_i sampled on accept
//   abort_i                       stop after the pulse in progress
//   busy_o                        burst in progress
//   done_o / done_count_o         completion strobe and number of pulses emitted
//   sclk_o                        divided clock

module clkdiv #(
    parameter int DIV       = 8,
    parameter int IDLE_HIGH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HI_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(DIV - DIV / 2 - 1);
    localparam logic IDLE_LVL = (IDLE_HIGH != 0);

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic          fresh_q;   // first idle cycle after a pulse (the RTI cycle)
    logic          cont_q;    // next pulse committed by en_i during the RTI cycle

    // Active level, phase counter and pulse state are deliberately not reset so
    // that a pulse in flight always completes with its full width.
    always_ff @(posedge clk_i) begin
        if (active_q) begin
            if (cnt_q == HI_LAST) begin
                active_q <= 1'b0;
                cnt_q    <= '0;
                fresh_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            fresh_q <= 1'b0;
            if (fresh_q) begin
                cont_q <= en_i;
            end
            // cnt_q saturates at LO_LAST once the cooldown has expired.
            if (cnt_q == LO_LAST) begin
                if (en_i || (cont_q && !fresh_q)) begin
                    active_q <= 1'b1;
                    cnt_q    <= '0;
                    cont_q   <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
        if (rst_i) begin
            cont_q <= 1'b0;
        end
    end

    assign sclk_o = active_q ^ IDLE_LVL;
endmodule

module clkdiv_burst #(
    parameter int DIV         = 8,
    parameter int IDLE_HIGH   = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [COUNT_WIDTH-1:0] req_count_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [COUNT_WIDTH-1:0] done_count_o,
    output logic                   sclk_o
);
    localparam int WW = $clog2(2 * DIV);
    localparam logic [WW-1:0] RESYNC_LAST = WW'(2 * DIV - 1);
    localparam logic [WW-1:0] DRAIN_LAST  = WW'(DIV - DIV / 2 - 1);
    localparam logic IDLE_LVL = (IDLE_HIGH != 0);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [WW-1:0]          wait_q;
    logic [COUNT_WIDTH-1:0] ends_q;
    logic [COUNT_WIDTH-1:0] n_q;
    logic [COUNT_WIDTH-1:0] done_count_q;
    logic                   abort_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   sclk_prev_q;
    logic                   sclk;
    logic                   en;
    logic                   rti;
    logic                   last_rti;
    logic [COUNT_WIDTH:0]   ends_inc;

    clkdiv #(
        .DIV       (DIV),
        .IDLE_HIGH (IDLE_HIGH)
    ) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en),
        .sclk_o (sclk)
    );

    // Widened by one bit so that ends+1 cannot wrap at the maximum count.
    assign ends_inc = {1'b0, ends_q} + (COUNT_WIDTH + 1)'(1);
    assign rti      = (sclk == IDLE_LVL) && (sclk_prev_q != IDLE_LVL);
    assign last_rti = (ends_inc == {1'b0, n_q});

    // Enable drops in the Nth RTI cycle, which is when the divider decides
    // whether another pulse follows.
    assign en = (state_q == S_START) ||
                ((state_q == S_RUN) && !abort_q && (ends_inc < {1'b0, n_q}));

    always_ff @(posedge clk_i) begin
        sclk_prev_q <= sclk;
        if (rst_i) begin
            state_q      <= S_RESYNC;
            wait_q       <= RESYNC_LAST;
            ends_q       <= '0;
            n_q          <= '0;
            abort_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (rti) begin
                ends_q <= ends_q + COUNT_WIDTH'(1);
            end
            case (state_q)
                S_RESYNC: begin
                    if (wait_q == '0) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                S_IDLE: begin
                    if (req_valid_i && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        ends_q  <= '0;
                        abort_q <= 1'b0;
                        n_q     <= req_count_i;
                        if (req_count_i == '0) begin
                            // Zero-count burst: a single drain cycle keeps its
                            // completion two cycles after the accept.
                            state_q <= S_DRAIN;
                            wait_q  <= '0;
                        end else begin
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                    end
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                    end
                    if (rti && (last_rti || abort_q)) begin
                        state_q <= S_DRAIN;
                        wait_q  <= DRAIN_LAST;
                    end
                end
                S_DRAIN: begin
                    if (wait_q == '0) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        done_count_q <= ends_q;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_RESYNC;
                    wait_q  <= RESYNC_LAST;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign done_count_o = done_count_q;
    assign sclk_o       = sclk;
endmodule

// File: tb/tb_clkdiv_burst.sv
// tb/tb_clkdiv_burst.sv - directed self-checking bench for clkdiv_burst
module tb_clkdiv_burst;
    localparam int CW    = 8;
    localparam int DIV_A = 8;
    localparam int DIV_B = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          a_valid = 1'b0, a_abort = 1'b0;
    logic [CW-1:0] a_count = '0;
    logic          a_ready, a_busy, a_done, a_sclk;
    logic [CW-1:0] a_done_count;

    logic          b_valid = 1'b0, b_abort = 1'b0;
    logic [CW-1:0] b_count = '0;
    logic          b_ready, b_busy, b_done, b_sclk;
    logic [CW-1:0] b_done_count;

    always #5 clk = ~clk;

    clkdiv_burst #(.DIV(DIV_A), .IDLE_HIGH(1), .COUNT_WIDTH(CW)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .req_count_i(a_count), .abort_i(a_abort), .busy_o(a_busy), .done_o(a_done),
        .done_count_o(a_done_count), .sclk_o(a_sclk)
    );

    clkdiv_burst #(.DIV(DIV_B), .IDLE_HIGH(0), .COUNT_WIDTH(CW)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_count_i(b_count), .abort_i(b_abort), .busy_o(b_busy), .done_o(b_done),
        .done_count_o(b_done_count), .sclk_o(b_sclk)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // sclk level-run monitors: RTIs, pulse starts, active widths, shortest level.
    logic a_prev = 1'b1;
    bit   a_first = 1'b1;
    int   a_run = 0, a_rti = 0, a_starts = 0, a_act_min = 1000, a_act_max = 0, a_min_run = 1000;
    logic b_prev = 1'b0;
    bit   b_first = 1'b1;
    int   b_run = 0, b_rti = 0, b_starts = 0, b_act_min = 1000, b_act_max = 0, b_min_run = 1000;

    always @(negedge clk) begin
        if (a_sclk == a_prev) begin
            a_run++;
        end else begin
            if (!a_first) begin
                if (a_run < a_min_run) a_min_run = a_run;
                if (a_prev == 1'b0) begin
                    if (a_run < a_act_min) a_act_min = a_run;
                    if (a_run > a_act_max) a_act_max = a_run;
                end
            end
            a_first = 1'b0;
            if (a_prev == 1'b0) a_rti++; else a_starts++;
            a_run = 1;
        end
        a_prev = a_sclk;
    end

    always @(negedge clk) begin
        if (b_sclk == b_prev) begin
            b_run++;
        end else begin
            if (!b_first) begin
                if (b_run < b_min_run) b_min_run = b_run;
                if (b_prev == 1'b1) begin
                    if (b_run < b_act_min) b_act_min = b_run;
                    if (b_run > b_act_max) b_act_max = b_run;
                end
            end
            b_first = 1'b0;
            if (b_prev == 1'b1) b_rti++; else b_starts++;
            b_run = 1;
        end
        b_prev = b_sclk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic drive_req(input bit sel, input bit v, input int n);
        if (sel) begin b_valid = v; b_count = CW'(n); end
        else     begin a_valid = v; a_count = CW'(n); end
    endtask

    task automatic wait_ready(input bit sel, input string tag);
        int k = 0;
        while (!(sel ? b_ready : a_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, int'(sel ? b_ready : a_ready), 1);
    endtask

    // Returns at the negedge of the cycle that starts at the accept edge.
    task automatic issue(input bit sel, input int n, input string tag);
        wait_ready(sel, tag);
        drive_req(sel, 1'b1, n);
        @(negedge clk);
        drive_req(sel, 1'b0, n);
    endtask

    task automatic wait_done(input bit sel, input int abort_at, input string tag,
                             output int cyc, output int cnt);
        int k = 0;
        while (!(sel ? b_done : a_done) && k < 4000) begin
            if (sel) b_abort = (k == abort_at); else a_abort = (k == abort_at);
            @(negedge clk);
            k++;
        end
        a_abort = 1'b0;
        b_abort = 1'b0;
        check({tag, "_done_seen"}, int'(sel ? b_done : a_done), 1);
        cyc = k;
        cnt = int'(sel ? b_done_count : a_done_count);
    endtask

    task automatic settle(input bit sel, input int rti0, input int exp_pulses, input string tag);
        repeat (2 * DIV_A) @(negedge clk);
        check({tag, "_pulses"}, (sel ? b_rti : a_rti) - rti0, exp_pulses);
        check({tag, "_sclk_idle"}, int'(sel ? b_sclk : a_sclk), sel ? 0 : 1);
    endtask

    initial begin
        int cyc, cnt, r0, s0, k;

        repeat (3) @(negedge clk);
        check("rst_ready", int'(a_ready), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_done_count", int'(a_done_count), 0);
        check("rst_ready_b", int'(b_ready), 0);
        rst = 1'b0;
        k = 0;
        while (!a_ready && k < 100) begin @(negedge clk); k++; end
        check("resync_len", k, 2 * DIV_A);

        // N=3: RTI3 at 1+2*8+4=21, done at 21+4+1=26
        r0 = a_rti;
        issue(0, 3, "n3");
        wait_done(0, -1, "n3", cyc, cnt);
        check("n3_done_cycle", cyc, 26);
        check("n3_done_count", cnt, 3);
        settle(0, r0, 3, "n3");

        // N=0: done two cycles after the accept cycle, no sclk activity
        r0 = a_rti;
        s0 = a_starts;
        issue(0, 0, "n0");
        wait_done(0, -1, "n0", cyc, cnt);
        check("n0_done_cycle", cyc, 1);
        check("n0_done_count", cnt, 0);
        settle(0, r0, 0, "n0");
        check("n0_no_start", a_starts - s0, 0);

        // N=1 then N=255 with valid held: done at 10, re-accept at cycle 11
        r0 = a_rti;
        wait_ready(0, "b2b");
        drive_req(0, 1'b1, 1);
        @(negedge clk);
        drive_req(0, 1'b1, 255);
        wait_done(0, -1, "b2b1", cyc, cnt);
        check("b2b1_done_cycle", cyc, 10);
        check("b2b1_done_count", cnt, 1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_reaccept_busy", int'(a_busy), 1);
        check("b2b_reaccept_ready", int'(a_ready), 0);
        drive_req(0, 1'b0, 255);
        wait_done(0, -1, "b2b2", cyc, cnt);
        check("b2b2_done_cycle", cyc, 1 + 254 * 8 + 4 + 4 + 1);
        check("b2b2_done_count", cnt, 255);
        settle(0, r0, 256, "b2b");

        // N=10, abort during pulse 3 (active cycles 17..20)
        r0 = a_rti;
        issue(0, 10, "abort");
        wait_done(0, 18, "abort", cyc, cnt);
        check("abort_done_cycle", cyc, 26);
        check("abort_done_count", cnt, 3);
        settle(0, r0, 3, "abort");

        // DIV=5, idle low, N=4: RTI4 at 1+15+2=18, done at 18+3+1=22
        r0 = b_rti;
        issue(1, 4, "d5");
        wait_done(1, -1, "d5", cyc, cnt);
        check("d5_done_cycle", cyc, 22);
        check("d5_done_count", cnt, 4);
        settle(1, r0, 4, "d5");
        check("d5_active_min", b_act_min, 2);
        check("d5_active_max", b_act_max, 2);
        check("d5_min_level", b_min_run, 2);

        // Reset in pulse 3 of a 10-pulse burst
        r0 = a_rti;
        s0 = a_starts;
        issue(0, 10, "rst_mid");
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", int'(a_busy), 0);
        check("rst_mid_done_count", int'(a_done_count), 0);
        k = 0;
        while (!a_ready && k < 100) begin @(negedge clk); k++; end
        check("rst_mid_resync_len", k, 2 * DIV_A);
        check("rst_mid_pulses", a_rti - r0, 3);
        check("rst_mid_starts", a_starts - s0, 3);
        check("rst_mid_sclk_idle", int'(a_sclk), 1);

        check("a_active_min", a_act_min, 4);
        check("a_active_max", a_act_max, 4);
        check("a_min_level", a_min_run, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
